// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response, redirect and decode handoff signals of the fetch stage.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4, id_opcode, id_funct3,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4, id_opcode, id_funct3,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32 program counter, credit-limited imem requests and in-order response buffer for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic         clk,
  input logic         reset,
  fetch_stage_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [31:0]   fetch_pc, rsp_pc, target;
  logic [CW-1:0] outstanding, drop_cnt, count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [CW:0]   credit;
  logic          pop, push, req;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    target = bus.redirect_pc & ~32'h3;
    pop = bus.id_valid && bus.id_ready;
    // In-flight requests plus buffered entries never exceed DEPTH, so a response always finds space.
    credit = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
    bus.imem_req_valid = !reset && !bus.redirect_valid && credit < (CW + 1)'(DEPTH);
    req = bus.imem_req_valid && bus.imem_req_ready;
    push = bus.imem_rsp_valid && drop_cnt == '0 && !bus.redirect_valid;
  end
  assign bus.imem_req_addr = fetch_pc;
  assign bus.id_valid      = count != '0;
  assign bus.id_instr      = instr_q[rd_ptr];
  assign bus.id_pc         = pc_q[rd_ptr];
  assign bus.id_pc_plus4   = bus.id_valid ? pc_q[rd_ptr] + 32'd4 : '0;
  assign bus.id_opcode     = instr_q[rd_ptr][6:0];
  assign bus.id_funct3     = instr_q[rd_ptr][14:12];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      outstanding <= outstanding + CW'(req) - CW'(bus.imem_rsp_valid);
      if (bus.redirect_valid) begin
        fetch_pc <= target;
        rsp_pc   <= target;
        drop_cnt <= outstanding - CW'(bus.imem_rsp_valid);
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req) fetch_pc <= fetch_pc + 32'd4;
        if (bus.imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (push) begin
          instr_q[wr_ptr] <= bus.imem_rsp_data;
          pc_q[wr_ptr]    <= rsp_pc;
          rsp_pc          <= rsp_pc + 32'd4;
          wr_ptr          <= nxt(wr_ptr);
        end
        if (pop) rd_ptr <= nxt(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  assert property (@(posedge clk) disable iff (reset) !(push && count == FULL));
endmodule
